// File: rtl/cv32e40p_obi_mem_slave.sv
// ---------------------------------------------------------------------------
// cv32e40p_obi_mem_slave
//
// OBI slave front-end for a single-port SRAM macro that has a 1-cycle read
// latency. Core requests are granted while there is room for their
// responses. Each granted access reaches the SRAM in the same cycle. Its
// response is formed one cycle later. The response goes straight to the
// core when nothing is queued ahead of it. Otherwise it is parked in an
// in-order response FIFO.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_i / gnt_o          OBI address-phase handshake
//   addr_i, we_i, be_i,    OBI request attributes (byte address, bits [1:0]
//   wdata_i                ignored)
//   rvalid_o, rdata_o,     OBI response phase (no back-pressure from core)
//   err_o
//   gnt_stall_i            forces gnt_o low (wait-state injection)
//   rvalid_stall_i         holds responses back (wait-state injection)
//   mem_req_o, mem_we_o,   SRAM strobe and write controls
//   mem_addr_o, mem_be_o,
//   mem_wdata_o
//   mem_rdata_i            SRAM read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module cv32e40p_obi_mem_slave #(
  parameter  int unsigned MEM_WORDS  = 4096,
  parameter  int unsigned RESP_DEPTH = 2,
  localparam int unsigned MEM_AW     = $clog2(MEM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  input  logic              gnt_stall_i,
  input  logic              rvalid_stall_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RESP_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(RESP_DEPTH);

  // Response FIFO storage and control
  logic [31:0]           fifo_rdata_reg [RESP_DEPTH];
  logic [RESP_DEPTH-1:0] fifo_err_reg;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      fifo_cnt_reg, fifo_cnt_next;

  // The transaction granted in the previous cycle whose response forms now
  logic                  pend_reg, pend_we_reg, pend_err_reg;

  logic [CNT_W:0]        occ;
  logic                  in_range;
  logic                  accept;
  logic                  fifo_empty, fifo_full;
  logic [31:0]           resp_rdata;
  logic                  bypass, push, pop;
  logic                  unused_addr_lsb;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign unused_addr_lsb = ^addr_i[1:0];

  // Every outstanding transaction is either parked in the FIFO or in flight
  // in the pend stage. Grant only while a slot is guaranteed for its response.
  assign occ      = {1'b0, fifo_cnt_reg} + {{CNT_W{1'b0}}, pend_reg};
  assign in_range = {2'b00, addr_i[31:2]} < 32'(MEM_WORDS);

  // Gated by rst_ni so that nothing is granted or strobed during reset.
  assign gnt_o  = rst_ni && req_i && !gnt_stall_i && (occ < DEPTH_OCC);
  assign accept = gnt_o;

  assign mem_req_o   = accept && in_range;
  assign mem_we_o    = we_i;
  assign mem_be_o    = be_i;
  assign mem_wdata_o = wdata_i;
  assign mem_addr_o  = addr_i[MEM_AW+1:2];

  assign fifo_empty = (fifo_cnt_reg == '0);
  assign fifo_full  = (fifo_cnt_reg == FULL_CNT);

  // Only a successful read returns SRAM data. Writes and errors return zero.
  assign resp_rdata = (!pend_we_reg && !pend_err_reg) ? mem_rdata_i : '0;

  // The fresh response may skip the FIFO only when nothing is queued ahead of it.
  assign bypass   = pend_reg && fifo_empty && !rvalid_stall_i;
  assign push     = pend_reg && !bypass;
  assign rvalid_o = rst_ni && (!fifo_empty || bypass) && !rvalid_stall_i;
  assign pop      = rvalid_o && !fifo_empty;

  always_comb begin
    rdata_o = '0;
    err_o   = 1'b0;
    if (rvalid_o) begin
      if (!fifo_empty) begin
        rdata_o = fifo_rdata_reg[rd_ptr_reg];
        err_o   = fifo_err_reg[rd_ptr_reg];
      end else begin
        rdata_o = resp_rdata;
        err_o   = pend_err_reg;
      end
    end
  end

  always_comb begin
    wr_ptr_next   = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next   = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    fifo_cnt_next = fifo_cnt_reg;
    if (push && !pop) begin
      fifo_cnt_next = fifo_cnt_reg + 1'b1;
    end else if (pop && !push) begin
      fifo_cnt_next = fifo_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_reg     <= 1'b0;
      pend_we_reg  <= 1'b0;
      pend_err_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      pend_reg <= accept;
      if (accept) begin
        pend_we_reg  <= we_i;
        pend_err_reg <= !in_range;
      end
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      fifo_cnt_reg <= fifo_cnt_next;
    end
  end

  // FIFO payload needs no reset: an entry is only read after it was written.
  generate
    for (genvar gi = 0; gi < RESP_DEPTH; gi++) begin : g_fifo_entry
      always_ff @(posedge clk_i) begin
        if (rst_ni && push && (wr_ptr_reg == PTR_W'(gi))) begin
          fifo_rdata_reg[gi] <= resp_rdata;
          fifo_err_reg[gi]   <= pend_err_reg;
        end
      end
    end
  endgenerate

`ifdef CV32E40P_ASSERT_ON
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && fifo_full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && fifo_empty));
  a_gnt_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    gnt_o |-> req_i);
`endif

endmodule

// File: tb/tb_cv32e40p_obi_mem_slave.sv
// ---------------------------------------------------------------------------
// Testbench for cv32e40p_obi_mem_slave.
// Inputs are driven on the falling edge. Outputs are checked 1 time unit
// later against a transaction-level model. The model tracks the outstanding
// response queue and a reference copy of memory. A behavioural SRAM with
// 1-cycle read latency is attached to the memory port.
// ---------------------------------------------------------------------------
module tb_cv32e40p_obi_mem_slave;

  localparam int unsigned MEM_WORDS  = 4096;
  localparam int unsigned RESP_DEPTH = 2;
  localparam int unsigned MEM_AW     = $clog2(MEM_WORDS);

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              req_i = 1'b0;
  logic              gnt_o;
  logic [31:0]       addr_i = '0;
  logic              we_i = 1'b0;
  logic [3:0]        be_i = '0;
  logic [31:0]       wdata_i = '0;
  logic              rvalid_o;
  logic [31:0]       rdata_o;
  logic              err_o;
  logic              gnt_stall_i = 1'b0;
  logic              rvalid_stall_i = 1'b0;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i = '0;

  cv32e40p_obi_mem_slave #(
    .MEM_WORDS (MEM_WORDS),
    .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .addr_i        (addr_i),
    .we_i          (we_i),
    .be_i          (be_i),
    .wdata_i       (wdata_i),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .gnt_stall_i   (gnt_stall_i),
    .rvalid_stall_i(rvalid_stall_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_be_o      (mem_be_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'hDEADBEEF;
      1:       return 32'h12345678;
      4:       return 32'h11111111;
      default: return 32'(i) * 32'h9E3779B9;
    endcase
  endfunction

  // Behavioural SRAM macro, preloaded on its first clock edge
  logic [31:0] sram [MEM_WORDS];
  logic        sram_init_done = 1'b0;

  always @(posedge clk_i) begin
    if (!sram_init_done) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) sram[i] <= init_word(i);
      sram_init_done <= 1'b1;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int k = 0; k < 4; k++)
          if (mem_be_o[k]) sram[mem_addr_o][k*8 +: 8] <= mem_wdata_o[k*8 +: 8];
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  // Reference model: memory image plus the queue of promised responses
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic [31:0] ref_mem [MEM_WORDS];
  resp_t       exp_q [$];

  int total = 0;
  int bad   = 0;
  int n_rsp = 0;

  logic        o_gnt, o_mem_req, o_rvalid, o_err;
  logic [31:0] o_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model exactly as the core would see it.
  task automatic step(input logic rn, input logic r, input logic [31:0] a,
                      input logic w, input logic [3:0] b, input logic [31:0] wd,
                      input logic gs, input logic rs);
    logic  e_gnt, e_inr, e_rv;
    int    idx;
    resp_t nr;
    @(negedge clk_i);
    rst_ni = rn; req_i = r; addr_i = a; we_i = w; be_i = b; wdata_i = wd;
    gnt_stall_i = gs; rvalid_stall_i = rs;
    #1;
    o_gnt = gnt_o; o_mem_req = mem_req_o; o_rvalid = rvalid_o;
    o_rdata = rdata_o; o_err = err_o;
    if (!rn) begin
      chk("rst_gnt", 32'(gnt_o), 0);
      chk("rst_rvalid", 32'(rvalid_o), 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_mem_req", 32'(mem_req_o), 0);
      exp_q.delete();
    end else begin
      e_gnt = r && !gs && (exp_q.size() < int'(RESP_DEPTH));
      e_inr = a[31:2] < MEM_WORDS;
      idx   = int'(a[MEM_AW+1:2]);
      chk("gnt", 32'(gnt_o), 32'(e_gnt));
      chk("mem_req", 32'(mem_req_o), 32'(e_gnt && e_inr));
      if (e_gnt && e_inr) begin
        chk("mem_addr", 32'(mem_addr_o), 32'(idx));
        chk("mem_we", 32'(mem_we_o), 32'(w));
        if (w) begin
          chk("mem_be", 32'(mem_be_o), 32'(b));
          chk("mem_wdata", mem_wdata_o, wd);
        end
      end
      e_rv = (exp_q.size() > 0) && !rs;
      chk("rvalid", 32'(rvalid_o), 32'(e_rv));
      if (e_rv) begin
        chk("rdata", rdata_o, exp_q[0].rdata);
        chk("err", 32'(err_o), 32'(exp_q[0].err));
        n_rsp++;
        $display("rsp %0d: rdata=%h err=%b", n_rsp, rdata_o, err_o);
        void'(exp_q.pop_front());
      end else begin
        chk("idle_rdata", rdata_o, 0);
        chk("idle_err", 32'(err_o), 0);
      end
      if (e_gnt) begin
        nr.err   = !e_inr;
        nr.rdata = (e_inr && !w) ? ref_mem[idx] : 32'h0;
        if (e_inr && w)
          for (int k = 0; k < 4; k++)
            if (b[k]) ref_mem[idx][k*8 +: 8] = wd[k*8 +: 8];
        exp_q.push_back(nr);
      end
    end
  endtask

  task automatic idle(input logic rs);
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, rs);
  endtask

  task automatic rd(input logic [31:0] a, input logic gs, input logic rs);
    step(1'b1, 1'b1, a, 1'b0, 4'hF, 32'h0, gs, rs);
  endtask

  initial begin
    logic        granted;
    logic [31:0] ra;
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = init_word(i);

    // Reset state
    step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

    // Back-to-back reads
    rd(32'h0, 1'b0, 1'b0);
    chk("b2b_gnt0", 32'(o_gnt), 1);
    rd(32'h4, 1'b0, 1'b0);
    chk("b2b_gnt1", 32'(o_gnt), 1);
    chk("b2b_rsp0", o_rdata, 32'hDEADBEEF);
    idle(1'b0);
    chk("b2b_rsp1", o_rdata, 32'h12345678);
    chk("b2b_err1", 32'(o_err), 0);
    idle(1'b0);

    // Partial write then read-back
    step(1'b1, 1'b1, 32'h10, 1'b1, 4'b0011, 32'hAABBCCDD, 1'b0, 1'b0);
    rd(32'h10, 1'b0, 1'b0);
    chk("wr_rsp_valid", 32'(o_rvalid), 1);
    chk("wr_rsp_rdata", o_rdata, 0);
    idle(1'b0);
    chk("rmw_rdata", o_rdata, 32'h1111CCDD);
    idle(1'b0);

    // Response stall fills the FIFO and blocks the third grant
    rd(32'h0, 1'b0, 1'b1);
    rd(32'h4, 1'b0, 1'b1);
    rd(32'h8, 1'b0, 1'b1);
    chk("rstall_third_held", 32'(o_gnt), 0);
    granted = 1'b0;
    for (int i = 0; i < 8 && !granted; i++) begin
      rd(32'h8, 1'b0, 1'b0);
      granted = o_gnt;
    end
    chk("rstall_third_granted", 32'(granted), 1);
    for (int i = 0; i < 3; i++) idle(1'b0);

    // Out-of-range read
    rd(32'(4 * MEM_WORDS), 1'b0, 1'b0);
    chk("err_no_mem_req", 32'(o_mem_req), 0);
    idle(1'b0);
    chk("err_flag", 32'(o_err), 1);
    chk("err_rdata", o_rdata, 0);

    // Grant stall
    for (int i = 0; i < 3; i++) begin
      rd(32'hC, 1'b1, 1'b0);
      chk("gstall_gnt", 32'(o_gnt), 0);
    end
    rd(32'hC, 1'b0, 1'b0);
    chk("gstall_release_gnt", 32'(o_gnt), 1);
    idle(1'b0);
    chk("gstall_rsp", o_rdata, init_word(3));

    // Reset with two responses parked in the FIFO
    rd(32'h0, 1'b0, 1'b1);
    rd(32'h4, 1'b0, 1'b1);
    idle(1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("post_rst_no_rvalid", 32'(o_rvalid), 0);
    end
    rd(32'h4, 1'b0, 1'b0);
    idle(1'b0);
    chk("post_rst_rsp", o_rdata, 32'h12345678);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0)
        ra = 32'(4 * MEM_WORDS) + ($urandom_range(0, 1023) << 2);
      else
        ra = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      step($urandom_range(0, 149) != 0, $urandom_range(0, 3) != 0, ra,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b0);
    chk("drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_obi_mem_slave.md
Name: cv32e40p_obi_mem_slave

Overview:
- OBI slave memory front-end sitting directly downstream of the core's data (or instruction) port.
- Accepts core requests (req/gnt/rvalid) and drives a single-port SRAM macro with 1-cycle read latency.
- Buffers responses in an in-order FIFO.
- Provides grant- and response-stall inputs so the bench can inject wait states on the core interface.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words in the attached SRAM; word addresses >= MEM_WORDS are errors.
- RESP_DEPTH, 2, response FIFO depth (>=1); also the maximum number of outstanding transactions.
- MEM_AW, $clog2(MEM_WORDS), SRAM word-address width (derived, not overridden).

Ports:
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset, synchronous, active-low.
- req_i, input, 1: OBI request.
- gnt_o, output, 1: OBI grant.
- addr_i, input, 32: byte address; bits [1:0] ignored.
- we_i, input, 1: write enable.
- be_i, input, 4: byte enables.
- wdata_i, input, 32: write data.
- rvalid_o, output, 1: response valid.
- rdata_o, output, 32: read data; 0 for writes and errors.
- err_o, output, 1: response error, valid with rvalid_o.
- gnt_stall_i, input, 1: forces gnt_o low while high.
- rvalid_stall_i, input, 1: holds responses in the FIFO while high.
- mem_req_o, output, 1: SRAM access strobe.
- mem_we_o, output, 1: SRAM write.
- mem_addr_o, output, MEM_AW: SRAM word address, addr_i[MEM_AW+1:2].
- mem_be_o, output, 4: SRAM byte enables.
- mem_wdata_o, output, 32: SRAM write data.
- mem_rdata_i, input, 32: SRAM read data, valid the cycle after mem_req_o && !mem_we_o.

Behaviour:
- Clocking and reset: single clock; rst_ni synchronous active-low.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, mem_req_o=0. FIFO empty, pend=0.
- Occupancy: occ = fifo_cnt + pend. pend is a 1-bit register set in any cycle with an accepted request.
- Grant: gnt_o = req_i && !gnt_stall_i && (occ < RESP_DEPTH). Combinational; no dependence on same-cycle pop.
- Accept: a transaction is accepted when req_i && gnt_o (cycle N).
  - Address range check: out of range when addr_i[31:2] >= MEM_WORDS.
  - In range: mem_req_o=1 in cycle N (combinational), with mem_we_o=we_i, mem_be_o=be_i, mem_wdata_o=wdata_i.
  - Out of range: mem_req_o=0.
  - Register pend_we, pend_err for cycle N+1.
- Response formation (cycle N+1, pend=1): resp = {err=pend_err, rdata}.
  - rdata = mem_rdata_i when !pend_we && !pend_err; otherwise 0.
- Bypass: if FIFO empty and !rvalid_stall_i, resp drives rvalid_o/rdata_o/err_o in N+1 directly. Minimum latency is 1 cycle after grant.
  - Otherwise resp is pushed into the FIFO in N+1.
- Output from FIFO:
  - rvalid_o = (fifo_cnt>0 || bypass) && !rvalid_stall_i.
  - The FIFO head has priority over bypass.
  - Pop when rvalid_o && fifo_cnt>0. The core always accepts rvalid (no rready).
- Ordering: responses are strictly in grant order. When the head pops while pend=1, the new resp is pushed in the same cycle (simultaneous push/pop; count unchanged).
- Full: occ==RESP_DEPTH blocks grant, so there is never a push into a full FIFO.
- Pointers: wrap modulo RESP_DEPTH.
- Reset mid-operation: pend and FIFO are cleared, and pending responses are dropped. An SRAM write strobed before reset still completes at the macro.
- Outputs when rvalid_o=0: rdata_o and err_o are driven 0 (no X leakage).
- Assertions (under CV32E40P_ASSERT_ON):
  - no push while full;
  - no pop while empty;
  - gnt_o implies req_i.

Test Plan:
- Back-to-back reads with preloaded mem[0]=0xDEADBEEF and mem[1]=0x12345678, req held 2 cycles at addr 0x0 then 0x4 → gnt_o in both cycles; rvalid in cycles N+1 and N+2 carrying 0xDEADBEEF then 0x12345678; err_o=0.
- Write then read: write addr 0x10, be=4'b0011, wdata=0xAABBCCDD over mem 0x11111111 → write rvalid rdata=0; following read of 0x10 returns 0x1111CCDD.
- Response stall, RESP_DEPTH=2: rvalid_stall_i=1 with 3 back-to-back reads → first 2 granted, third held with gnt_o=0. Release the stall → 2 responses in order on consecutive cycles, then third granted; response 1 cycle later.
- Error: read at addr 4*MEM_WORDS → mem_req_o stays 0; rvalid next cycle with err_o=1, rdata_o=0.
- Grant stall: gnt_stall_i=1 for 3 cycles with req_i high → gnt_o=0 and no mem_req_o for those cycles; grant in the cycle the stall drops, response 1 cycle later.
- Reset mid-operation: fill FIFO with 2 stalled responses, then rst_ni=0 for 1 cycle → all outputs 0; after release with stall low, no rvalid occurs until a new request is granted.
